// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam int         PERF_W  = 16;

endpackage

// File: rtl/arb_prio_starve.sv
// DM-priority winner select with a saturating starvation counter that
// hands the port to fetch after STARVE_MAX back-to-back DM wins.
module arb_prio_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic arb_en,
    output logic win_if,
    output logic win_dm
);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       starved;

    always_comb begin
        starved      = (starve_cnt_q == 4'(STARVE_MAX));
        win_dm       = arb_en && dm_req && !(if_req && starved);
        win_if       = arb_en && if_req && (!dm_req || starved);
        starve_cnt_d = starve_cnt_q;
        if (arb_en) begin
            // An idle look with fetch quiet also counts as progress for fetch.
            if (win_if || !if_req) begin
                starve_cnt_d = '0;
            end else if (win_dm && !starved) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data access, one transaction
// at a time. Define MEM_PORT_ARB_PERF_EN to add saturating perf counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_if_grants,
    output logic [PERF_W-1:0] perf_dm_grants,
    output logic [PERF_W-1:0] perf_conflict_cycles
`endif
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              arb_en, win_if, win_dm;

    assign arb_en = (state_q == IDLE);

    arb_prio_starve #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .dm_req (dm_req),
        .arb_en (arb_en),
        .win_if (win_if),
        .win_dm (win_dm)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        wait_cnt_d  = wait_cnt_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = '0;
        dm_rdata_d  = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (win_dm) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_DM;
                    we_d        = dm_we;
                    dm_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = (dm_be == BE_WORD) ? (dm_addr & ~ADDR_W'(1)) : dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (win_if) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_IF;
                    we_d        = 1'b0;
                    if_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_be_d    = BE_WORD;
                    mem_addr_d  = if_addr & ~ADDR_W'(1);
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                // The response register is loaded on the last WAIT edge so RESP is one cycle.
                if (wait_cnt_q == 3'(MEM_LAT - 1)) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = we_q ? '0 : mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            wait_cnt_q  <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            wait_cnt_q  <= wait_cnt_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

`ifdef MEM_PORT_ARB_PERF_EN
    logic [PERF_W-1:0] perf_if_q, perf_if_d, perf_dm_q, perf_dm_d, perf_cf_q, perf_cf_d;

    always_comb begin
        perf_if_d = perf_if_q;
        perf_dm_d = perf_dm_q;
        perf_cf_d = perf_cf_q;
        if (win_if && perf_if_q != '1) perf_if_d = perf_if_q + PERF_W'(1);
        if (win_dm && perf_dm_q != '1) perf_dm_d = perf_dm_q + PERF_W'(1);
        if (if_req && dm_req && perf_cf_q != '1) perf_cf_d = perf_cf_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_dm_q <= perf_dm_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_if_grants       = perf_if_q;
    assign perf_dm_grants       = perf_dm_q;
    assign perf_conflict_cycles = perf_cf_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch stage (IF) and the memory-access stage (DM) of the XM23 pipeline.
- Runs one transaction at a time: priority arbitration, registered issue, fixed-latency response capture and return to the owning requester.
- DM has priority. A starvation limiter guarantees that fetch makes forward progress.

Parameters:
- ADDR_W, 16, address width (byte address)
- DATA_W, 16, data width (one XM23 word)
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..7
- STARVE_MAX, 4, consecutive DM grants allowed while if_req is pending; legal range 1..15

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid
- if_rdata  out  DATA_W  fetched word
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  2  byte enables: 01 = low byte, 10 = high byte, 11 = word
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle grant pulse to DM
- dm_rvalid  out  1  one-cycle completion pulse (loads and stores)
- dm_rdata  out  DATA_W  load data; 0 for stores
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_be  out  2  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0, owner IF.
- Reset mid-transaction is asynchronous. Any in-flight response is discarded and no rvalid is issued.
- All outputs are registered.
- States:
  - IDLE: with no request pending, stay in IDLE.
  - IDLE to ISSUE: when if_req or dm_req is sampled at a posedge.
  - ISSUE: lasts exactly 1 cycle. The winner's gnt = 1; mem_en = 1; mem_addr, mem_we, mem_be and mem_wdata are driven from the values captured at that edge. Fetch transactions drive mem_we = 0 and mem_be = 11. Then go to WAIT.
  - WAIT: lasts MEM_LAT cycles. All mem_* outputs are 0. On the final edge, mem_rdata is captured. Then go to RESP.
  - RESP: lasts 1 cycle. The owner's rvalid = 1 and rdata = the captured word (dm_rdata = 0 for stores). Then go to IDLE.
- Latency: request sampled at edge N gives gnt in cycle N+1 and rvalid in cycle N+2+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
- Arbitration, evaluated only in IDLE:
  - dm_req alone: DM wins.
  - if_req alone: IF wins.
  - Both requesting: DM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt rules:
  - Increments, saturating at STARVE_MAX, on each DM grant made while if_req = 1.
  - Clears on an IF grant.
  - Clears on any IDLE cycle with if_req = 0.
- Word alignment: when the captured be == 11, mem_addr[0] is forced to 0. Byte accesses pass the address unmodified.
- A store with dm_be == 00 is issued with mem_we = 1 and mem_be = 00. It completes normally with no memory effect.
- Request withdrawn before grant: permitted. Nothing is issued, because arbitration re-samples in IDLE.
- Requests arriving while busy are ignored until the next IDLE evaluation. Requesters must hold request and payload until their gnt.

Optional Feature:
- Macro: MEM_PORT_ARB_PERF_EN.
- When defined, adds three outputs, each 16 bits and saturating at 16'hFFFF, all cleared by reset:
  - perf_if_grants: counts IF grants.
  - perf_dm_grants: counts DM grants.
  - perf_conflict_cycles: counts cycles with both if_req and dm_req high.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t: IDLE, ISSUE, WAIT, RESP
  - typedef enum logic owner_t: OWN_IF, OWN_DM
  - localparam BE_WORD = 2'b11
  - localparam PERF_W = 16
- One sub-module, arb_prio_starve: combinational winner select plus the registered starvation counter. Inputs: if_req, dm_req, arb_en (IDLE). Outputs: win_if, win_dm.

Test Plan:
- Fetch only: if_req=1, if_addr=16'h0100, mem_rdata=16'h4008, MEM_LAT=1 -> if_gnt in cycle 1, mem_en with mem_addr=16'h0100 and mem_we=0 in cycle 1, if_rvalid with if_rdata=16'h4008 in cycle 3, busy=0 in cycle 4.
- Data load: dm_req=1, dm_we=0, dm_be=11, dm_addr=16'h0203 -> mem_addr=16'h0202, mem_be=11, dm_rvalid after MEM_LAT+2 cycles; byte store dm_be=10, dm_wdata=16'hAB00 -> mem_we=1, mem_be=10, dm_rdata=0.
- Contention, STARVE_MAX=4: if_req and dm_req held high continuously -> grant order DM, DM, DM, DM, IF, then DM resumes; if_req low for one IDLE cycle -> starve_cnt clears.
- Withdrawal and busy: request dropped before grant -> no gnt and no mem_en; new request raised during WAIT -> serviced only after RESP returns to IDLE.
- Reset mid-WAIT: reset low for 1 cycle during WAIT -> all outputs 0 immediately, no rvalid; a subsequent if_req is serviced normally.
- MEM_PORT_ARB_PERF_EN defined: 3 IF grants, 5 DM grants, 6 conflict cycles -> perf counters read 3, 5, 6; force 16'hFFFF and add one more event -> value holds at 16'hFFFF.
